nibble_packer: RTL and testbench

- Write-side counterpart of the nibble selector array: it takes 4-bit nibbles and scatters them into two 32-bit word assemblers, A and B.
- Each lane carries one nibble, a 3-bit nibble-position index per word and a word-select bit.
- A word is presented on its own valid/ready output port once all 8 of its nibble positions have been written.
- Double-buffered per word: an assembly buffer plus an output register.

---
 rtl/nibble_packer_if.sv | 30 +++
 rtl/nibble_packer.sv | 150 +++++++++++++++
 tb/tb_nibble_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_packer_if.sv
// Nibble packer bus: lane-parallel input beat plus two independent word output channels.
// The err line is only driven by logic when NIBBLE_PACKER_ERR_EN is defined.
interface nibble_packer_if #(
   parameter int unsigned NumLanes = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [4*NumLanes-1:0]   nibble_in;
   logic [NumLanes-1:0]     lane_en;
   logic [3*NumLanes-1:0]   ps_pos_a;
   logic [3*NumLanes-1:0]   ps_pos_b;
   logic [NumLanes-1:0]     ps_sel;
   logic [31:0]             data_a;
   logic                    out_valid_a;
   logic                    out_ready_a;
   logic [31:0]             data_b;
   logic                    out_valid_b;
   logic                    out_ready_b;
   logic                    err;

   modport slave (
      input  in_valid, nibble_in, lane_en, ps_pos_a, ps_pos_b, ps_sel, out_ready_a, out_ready_b,
      output in_ready, data_a, out_valid_a, data_b, out_valid_b, err
   );

   modport master (
      output in_valid, nibble_in, lane_en, ps_pos_a, ps_pos_b, ps_sel, out_ready_a, out_ready_b,
      input  in_ready, data_a, out_valid_a, data_b, out_valid_b, err
   );
endinterface

// File: rtl/nibble_packer.sv
// Scatters 4-bit lane nibbles into two double-buffered 32-bit word assemblers (index 0 = A, 1 = B).
// Optional sticky overwrite detection on err is built only when NIBBLE_PACKER_ERR_EN is defined.
module nibble_packer #(
   parameter int unsigned NumLanes    = 4,
   parameter int unsigned WordNibbles = 8
) (
   input logic            clk,
   input logic            reset,
   nibble_packer_if.slave bus
);

   localparam int unsigned NumWords = 2;
   localparam int unsigned WordBits = 4 * WordNibbles;

   typedef logic [WordBits-1:0]    word_t;
   typedef logic [WordNibbles-1:0] mask_t;

   word_t               asm_q       [NumWords];
   mask_t               mask_q      [NumWords];
   word_t               data_q      [NumWords];
   logic [NumWords-1:0] valid_q;

   word_t               merged_asm  [NumWords];
   mask_t               merged_mask [NumWords];
   logic [2:0]          lane_pos    [NumLanes];
   logic [NumWords-1:0] full;
   logic [NumWords-1:0] xfer;
   logic [NumWords-1:0] out_ready;
   logic                blocked;
   logic                in_ready;
   logic                fire;

   always_comb begin : pos_select
      for (int unsigned i = 0; i < NumLanes; i++) begin
         lane_pos[i] = bus.ps_sel[i] ? bus.ps_pos_b[i*3 +: 3] : bus.ps_pos_a[i*3 +: 3];
      end
   end

   // Stall only on lanes aimed at a buffer that is already full and waiting on its output.
   always_comb begin : ready_logic
      blocked = 1'b0;
      for (int unsigned w = 0; w < NumWords; w++) begin
         full[w] = &mask_q[w];
      end
      for (int unsigned i = 0; i < NumLanes; i++) begin
         if (bus.lane_en[i] && full[bus.ps_sel[i]]) begin
            blocked = 1'b1;
         end
      end
      in_ready = !reset && !blocked;
      fire     = bus.in_valid && in_ready;
   end

   // Ascending lane order lets the highest lane win a same-position collision.
   always_comb begin : merge_logic
      for (int unsigned w = 0; w < NumWords; w++) begin
         merged_asm[w]  = asm_q[w];
         merged_mask[w] = mask_q[w];
      end
      if (fire) begin
         for (int unsigned i = 0; i < NumLanes; i++) begin
            if (bus.lane_en[i]) begin
               merged_asm[bus.ps_sel[i]][{lane_pos[i], 2'b00} +: 4] = bus.nibble_in[i*4 +: 4];
               merged_mask[bus.ps_sel[i]][lane_pos[i]]              = 1'b1;
            end
         end
      end
   end

   always_comb begin : xfer_logic
      out_ready = {bus.out_ready_b, bus.out_ready_a};
      for (int unsigned w = 0; w < NumWords; w++) begin
         xfer[w] = (&merged_mask[w]) && (!valid_q[w] || out_ready[w]);
      end
   end

   // The assembly buffer keeps stale nibbles after a transfer; only the mask marks validity.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned w = 0; w < NumWords; w++) begin
            asm_q[w]   <= '0;
            mask_q[w]  <= '0;
            data_q[w]  <= '0;
            valid_q[w] <= 1'b0;
         end
      end else begin
         for (int unsigned w = 0; w < NumWords; w++) begin
            asm_q[w]  <= merged_asm[w];
            mask_q[w] <= xfer[w] ? '0 : merged_mask[w];
            if (xfer[w]) begin
               data_q[w]  <= merged_asm[w];
               valid_q[w] <= 1'b1;
            end else if (out_ready[w]) begin
               valid_q[w] <= 1'b0;
            end
         end
      end
   end

`ifdef NIBBLE_PACKER_ERR_EN
   mask_t hit [NumWords];
   logic  overwrite;
   logic  err_q;

   // hit tracks positions written earlier in this beat so lane collisions also flag.
   always_comb begin : overwrite_detect
      overwrite = 1'b0;
      for (int unsigned w = 0; w < NumWords; w++) begin
         hit[w] = '0;
      end
      if (fire) begin
         for (int unsigned i = 0; i < NumLanes; i++) begin
            if (bus.lane_en[i]) begin
               if (mask_q[bus.ps_sel[i]][lane_pos[i]] || hit[bus.ps_sel[i]][lane_pos[i]]) begin
                  overwrite = 1'b1;
               end
               hit[bus.ps_sel[i]][lane_pos[i]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (overwrite) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready    = in_ready;
   assign bus.data_a      = data_q[0];
   assign bus.out_valid_a = valid_q[0];
   assign bus.data_b      = data_q[1];
   assign bus.out_valid_b = valid_q[1];

   for (genvar w = 0; w < NumWords; w++) begin : g_chk
      assert property (@(posedge clk) disable iff (reset) xfer[w] |=> valid_q[w]);
      assert property (@(posedge clk) disable iff (reset)
                       (full[w] && valid_q[w] && !out_ready[w]) |=> full[w]);
   end

   assert property (@(posedge clk) reset |-> !bus.in_ready);

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer; expected words are hand-computed constants.
// Honours NIBBLE_PACKER_ERR_EN for the expected err value.
module tb_nibble_packer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   nibble_packer_if #(.NumLanes(4)) bus ();

   nibble_packer #(
      .NumLanes    (4),
      .WordNibbles (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef NIBBLE_PACKER_ERR_EN
   localparam logic ExpErr = 1'b1;
`else
   localparam logic ExpErr = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.lane_en   = '0;
      bus.nibble_in = '0;
      bus.ps_pos_a  = '0;
      bus.ps_pos_b  = '0;
      bus.ps_sel    = '0;
   endtask

   task automatic set_beat(input logic [15:0] nib, input logic [3:0] en, input logic [3:0] sel,
                           input logic [11:0] pa, input logic [11:0] pb);
      bus.nibble_in = nib;
      bus.lane_en   = en;
      bus.ps_sel    = sel;
      bus.ps_pos_a  = pa;
      bus.ps_pos_b  = pb;
      bus.in_valid  = 1'b1;
   endtask

   task automatic beat(input logic [15:0] nib, input logic [3:0] en, input logic [3:0] sel,
                       input logic [11:0] pa, input logic [11:0] pb);
      set_beat(nib, en, sel, pa, pb);
      step();
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_beat(16'hFFFF, 4'hF, 4'h0, 12'o3210, 12'o3210);
      step();
      step();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
      end
      checks++;
      if ({bus.out_valid_a, bus.out_valid_b, bus.err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags: got va=%b vb=%b err=%b want 0 0 0",
                  bus.out_valid_a, bus.out_valid_b, bus.err);
      end
      checks++;
      if ({bus.data_a, bus.data_b} !== 64'h0) begin
         failures++;
         $display("FAIL reset_data: got a=%h b=%h want 0 0", bus.data_a, bus.data_b);
      end
      idle();
      reset = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_fill_a();
      bus.out_ready_a = 1'b1;
      beat(16'h4321, 4'hF, 4'h0, 12'o3210, 12'o0000);
      checks++;
      if (bus.out_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL fill_a_half_valid: got %b want 0", bus.out_valid_a);
      end
      beat(16'h8765, 4'hF, 4'h0, 12'o7654, 12'o0000);
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a !== 32'h87654321) begin
         failures++;
         $display("FAIL fill_a_word: got v=%b d=%h want 1 87654321", bus.out_valid_a, bus.data_a);
      end
      checks++;
      if (bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL fill_a_b_quiet: got %b want 0", bus.out_valid_b);
      end
      step();
      checks++;
      if (bus.out_valid_a !== 1'b0 || bus.data_a !== 32'h87654321) begin
         failures++;
         $display("FAIL fill_a_drain: got v=%b d=%h want 0 87654321", bus.out_valid_a, bus.data_a);
      end
   endtask

   task automatic test_empty_beat();
      set_beat(16'hFFFF, 4'h0, 4'h0, 12'o7777, 12'o7777);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL empty_beat_ready: got %b want 1", bus.in_ready);
      end
      step();
      idle();
      step();
      checks++;
      if (bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL empty_beat_effect: got va=%b vb=%b want 0 0",
                  bus.out_valid_a, bus.out_valid_b);
      end
   endtask

   task automatic test_mixed();
      bus.out_ready_a = 1'b1;
      bus.out_ready_b = 1'b1;
      beat(16'hDCBA, 4'hF, 4'b1010, 12'o0100, 12'o1000);
      checks++;
      if (bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL mixed_no_output: got va=%b vb=%b want 0 0",
                  bus.out_valid_a, bus.out_valid_b);
      end
      beat(16'h3210, 4'hF, 4'h0, 12'o5432, 12'o0000);
      beat(16'h0054, 4'h3, 4'h0, 12'o0076, 12'o0000);
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a !== 32'h543210CA) begin
         failures++;
         $display("FAIL mixed_word_a: got v=%b d=%h want 1 543210ca", bus.out_valid_a, bus.data_a);
      end
      checks++;
      if (bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL mixed_b_early: got %b want 0", bus.out_valid_b);
      end
      beat(16'h7654, 4'hF, 4'hF, 12'o0000, 12'o5432);
      beat(16'h0098, 4'h3, 4'hF, 12'o0000, 12'o0076);
      checks++;
      if (bus.out_valid_b !== 1'b1 || bus.data_b !== 32'h987654DB) begin
         failures++;
         $display("FAIL mixed_word_b: got v=%b d=%h want 1 987654db", bus.out_valid_b, bus.data_b);
      end
      step();
   endtask

   task automatic test_backpressure();
      bus.out_ready_a = 1'b0;
      beat(16'h4321, 4'hF, 4'h0, 12'o3210, 12'o0000);
      beat(16'h8765, 4'hF, 4'h0, 12'o7654, 12'o0000);
      beat(16'hDCBA, 4'hF, 4'h0, 12'o3210, 12'o0000);
      beat(16'h10FE, 4'hF, 4'h0, 12'o7654, 12'o0000);
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a !== 32'h87654321) begin
         failures++;
         $display("FAIL bp_first_held: got v=%b d=%h want 1 87654321", bus.out_valid_a, bus.data_a);
      end
      set_beat(16'h0001, 4'h1, 4'h0, 12'o0000, 12'o0000);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_a_stall: got in_ready=%b want 0", bus.in_ready);
      end
      step();
      set_beat(16'h1234, 4'hF, 4'hF, 12'o0000, 12'o3210);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_b_accept: got in_ready=%b want 1", bus.in_ready);
      end
      step();
      idle();
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a !== 32'h87654321) begin
         failures++;
         $display("FAIL bp_still_held: got v=%b d=%h want 1 87654321", bus.out_valid_a, bus.data_a);
      end
      bus.out_ready_a = 1'b1;
      step();
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a !== 32'h10FEDCBA) begin
         failures++;
         $display("FAIL bp_second_word: got v=%b d=%h want 1 10fedcba", bus.out_valid_a, bus.data_a);
      end
      step();
      checks++;
      if (bus.out_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL bp_drained: got %b want 0", bus.out_valid_a);
      end
      beat(16'h8765, 4'hF, 4'hF, 12'o0000, 12'o7654);
      checks++;
      if (bus.out_valid_b !== 1'b1 || bus.data_b !== 32'h87651234) begin
         failures++;
         $display("FAIL bp_b_word: got v=%b d=%h want 1 87651234", bus.out_valid_b, bus.data_b);
      end
      step();
   endtask

   task automatic test_collision();
      bus.out_ready_a = 1'b1;
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL collision_err_before: got %b want 0", bus.err);
      end
      beat(16'h9001, 4'b1001, 4'h0, 12'o5005, 12'o0000);
      checks++;
      if (bus.err !== ExpErr) begin
         failures++;
         $display("FAIL collision_err: got %b want %b", bus.err, ExpErr);
      end
      beat(16'h4321, 4'hF, 4'h0, 12'o3210, 12'o0000);
      beat(16'h0875, 4'h7, 4'h0, 12'o0764, 12'o0000);
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.data_a[23:20] !== 4'h9) begin
         failures++;
         $display("FAIL collision_winner: got v=%b nib=%h want 1 9", bus.out_valid_a,
                  bus.data_a[23:20]);
      end
      checks++;
      if (bus.data_a !== 32'h87954321) begin
         failures++;
         $display("FAIL collision_word: got %h want 87954321", bus.data_a);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.out_ready_b = 1'b1;
      beat(16'h3333, 4'hF, 4'hF, 12'o0000, 12'o3210);
      beat(16'h0033, 4'h3, 4'hF, 12'o0000, 12'o0054);
      checks++;
      if (bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_partial: got %b want 0", bus.out_valid_b);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_ready: got %b want 0", bus.in_ready);
      end
      step();
      reset = 1'b0;
      checks++;
      if (bus.out_valid_b !== 1'b0 || bus.data_b !== 32'h0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_clear: got vb=%b db=%h err=%b want 0 0 0",
                  bus.out_valid_b, bus.data_b, bus.err);
      end
      beat(16'hFEDC, 4'hF, 4'hF, 12'o0000, 12'o7654);
      checks++;
      if (bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_residue: got %b want 0", bus.out_valid_b);
      end
      beat(16'hBA98, 4'hF, 4'hF, 12'o0000, 12'o3210);
      checks++;
      if (bus.out_valid_b !== 1'b1 || bus.data_b !== 32'hFEDCBA98) begin
         failures++;
         $display("FAIL reset_mid_word: got v=%b d=%h want 1 fedcba98", bus.out_valid_b, bus.data_b);
      end
      step();
   endtask

   task automatic test_simultaneous();
      bus.out_ready_a = 1'b1;
      bus.out_ready_b = 1'b1;
      beat(16'h3210, 4'hF, 4'h0, 12'o3210, 12'o0000);
      beat(16'h0054, 4'h3, 4'h0, 12'o0054, 12'o0000);
      beat(16'hBA98, 4'hF, 4'hF, 12'o0000, 12'o3210);
      beat(16'h00DC, 4'h3, 4'hF, 12'o0000, 12'o0054);
      checks++;
      if (bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL simul_prefill: got va=%b vb=%b want 0 0", bus.out_valid_a, bus.out_valid_b);
      end
      beat(16'hFE76, 4'hF, 4'b1100, 12'o0076, 12'o7600);
      checks++;
      if (bus.out_valid_a !== 1'b1 || bus.out_valid_b !== 1'b1) begin
         failures++;
         $display("FAIL simul_valid: got va=%b vb=%b want 1 1", bus.out_valid_a, bus.out_valid_b);
      end
      checks++;
      if (bus.data_a !== 32'h76543210 || bus.data_b !== 32'hFEDCBA98) begin
         failures++;
         $display("FAIL simul_data: got a=%h b=%h want 76543210 fedcba98", bus.data_a, bus.data_b);
      end
      step();
      checks++;
      if (bus.out_valid_a !== 1'b0 || bus.out_valid_b !== 1'b0) begin
         failures++;
         $display("FAIL simul_drain: got va=%b vb=%b want 0 0", bus.out_valid_a, bus.out_valid_b);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      bus.out_ready_a = 1'b1;
      bus.out_ready_b = 1'b1;
      idle();
      #1;
      test_reset();
      test_fill_a();
      test_empty_beat();
      test_mixed();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_simultaneous();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
